score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 219 +++++++++++++++++++++
 tb/tb_score_keeper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Purpose : pong-style score keeper; serve hold-off, goal edge detection, win detection.
// Latency : goal edge sampled on a clk edge updates scores/state on that same edge; all outputs registered.
// Backpressure: none; goal/frame_tick/new_game are sampled every cycle and never stalled.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   goal_left / goal_right  ball-out levels (left out awards right player, right out awards left)
//   frame_tick              one-cycle pulse per video frame, paces the serve hold-off
//   new_game                one-cycle request: clear scores and go back to serve wait
//   score_left/score_right  3-bit saturating point totals
//   ball_enable             high while the rally is live (PLAY)
//   serve                   one-cycle pulse when a rally starts
//   serve_dir               0 = serve toward left player, 1 = toward right player
//   win / winner            game over flag and who won (0 = left, 1 = right)
//
// Build option: define SCORE_KEEPER_AUTO_RESTART_EN to leave GAME_OVER on its own
// after RESTART_FRAMES frame ticks; otherwise only new_game or reset leave it.
module score_keeper #(
    parameter int WIN_SCORE      = 7,
    parameter int HOLD_FRAMES    = 60,
    parameter int RESTART_FRAMES = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       goal_left,
    input  logic       goal_right,
    input  logic       frame_tick,
    input  logic       new_game,
    output logic [2:0] score_left,
    output logic [2:0] score_right,
    output logic       ball_enable,
    output logic       serve,
    output logic       serve_dir,
    output logic       win,
    output logic       winner
);

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        GAME_OVER  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_FRAMES);
    localparam logic [2:0] WIN_VAL   = 3'(WIN_SCORE);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;

    // Previous-sample history of the goal levels; reset to 1 so a ball
    // already out of bounds when reset releases does not look like a new goal.
    logic       goal_left_q;
    logic       goal_right_q;
    logic       goal_left_edge;
    logic       goal_right_edge;

    logic [2:0] score_left_nxt;
    logic [2:0] score_right_nxt;
    logic       serve_dir_nxt;
    logic       winner_nxt;
    logic       ball_enable_nxt;
    logic       serve_nxt;
    logic       win_nxt;

`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    localparam logic [7:0] RESTART_LOAD = 8'(RESTART_FRAMES);
    logic [7:0] restart_cnt;
    logic [7:0] restart_cnt_nxt;
`endif

    assign goal_left_edge  = goal_left  & ~goal_left_q;
    assign goal_right_edge = goal_right & ~goal_right_q;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SERVE_WAIT;
            hold_cnt     <= HOLD_LOAD;
            goal_left_q  <= 1'b1;
            goal_right_q <= 1'b1;
            score_left   <= 3'd0;
            score_right  <= 3'd0;
            ball_enable  <= 1'b0;
            serve        <= 1'b0;
            serve_dir    <= 1'b0;
            win          <= 1'b0;
            winner       <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            goal_left_q  <= goal_left;
            goal_right_q <= goal_right;
            score_left   <= score_left_nxt;
            score_right  <= score_right_nxt;
            ball_enable  <= ball_enable_nxt;
            serve        <= serve_nxt;
            serve_dir    <= serve_dir_nxt;
            win          <= win_nxt;
            winner       <= winner_nxt;
        end
    end

`ifdef SCORE_KEEPER_AUTO_RESTART_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            restart_cnt <= RESTART_LOAD;
        end else begin
            restart_cnt <= restart_cnt_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        hold_cnt_nxt    = hold_cnt;
        score_left_nxt  = score_left;
        score_right_nxt = score_right;
        serve_dir_nxt   = serve_dir;
        winner_nxt      = winner;
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
        restart_cnt_nxt = restart_cnt;
`endif

        if (new_game) begin
            // Restart request beats any goal edge or tick seen this cycle.
            state_nxt       = SERVE_WAIT;
            score_left_nxt  = 3'd0;
            score_right_nxt = 3'd0;
            serve_dir_nxt   = 1'b0;
        end else begin
            case (state)
                SERVE_WAIT: begin
                    if (frame_tick) begin
                        if (hold_cnt <= 8'd1) begin
                            hold_cnt_nxt = 8'd0;
                            state_nxt    = PLAY;
                        end else begin
                            hold_cnt_nxt = hold_cnt - 8'd1;
                        end
                    end
                end

                PLAY: begin
                    if (goal_left_edge && goal_right_edge) begin
                        // Ambiguous double goal: nobody scores, serve is replayed.
                        state_nxt = SERVE_WAIT;
                    end else if (goal_left_edge) begin
                        score_right_nxt = sat_inc(score_right);
                        serve_dir_nxt   = 1'b0;
                        if (score_right_nxt == WIN_VAL) begin
                            state_nxt  = GAME_OVER;
                            winner_nxt = 1'b1;
                        end else begin
                            state_nxt  = SERVE_WAIT;
                        end
                    end else if (goal_right_edge) begin
                        score_left_nxt = sat_inc(score_left);
                        serve_dir_nxt  = 1'b1;
                        if (score_left_nxt == WIN_VAL) begin
                            state_nxt  = GAME_OVER;
                            winner_nxt = 1'b0;
                        end else begin
                            state_nxt  = SERVE_WAIT;
                        end
                    end
                end

                GAME_OVER: begin
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
                    if (frame_tick) begin
                        if (restart_cnt <= 8'd1) begin
                            restart_cnt_nxt = 8'd0;
                            state_nxt       = SERVE_WAIT;
                            score_left_nxt  = 3'd0;
                            score_right_nxt = 3'd0;
                            serve_dir_nxt   = 1'b0;
                        end else begin
                            restart_cnt_nxt = restart_cnt - 8'd1;
                        end
                    end
`endif
                end

                default: begin
                    state_nxt = SERVE_WAIT;
                end
            endcase
        end

        // Every entry into SERVE_WAIT (including new_game while already
        // waiting) restarts the full hold-off.
        if (state_nxt == SERVE_WAIT && (state != SERVE_WAIT || new_game)) begin
            hold_cnt_nxt = HOLD_LOAD;
        end

`ifdef SCORE_KEEPER_AUTO_RESTART_EN
        if (state_nxt == GAME_OVER && state != GAME_OVER) begin
            restart_cnt_nxt = RESTART_LOAD;
        end
`endif

        // Outputs are decoded from the next state so they register alongside it.
        ball_enable_nxt = (state_nxt == PLAY);
        win_nxt         = (state_nxt == GAME_OVER);
        serve_nxt       = (state == SERVE_WAIT) && (state_nxt == PLAY);
    end

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       goal_left  = 1'b0;
    logic       goal_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic       new_game   = 1'b0;
    logic [2:0] score_left;
    logic [2:0] score_right;
    logic       ball_enable;
    logic       serve;
    logic       serve_dir;
    logic       win;
    logic       winner;

    score_keeper #(
        .WIN_SCORE      (3),
        .HOLD_FRAMES    (2),
        .RESTART_FRAMES (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .goal_left   (goal_left),
        .goal_right  (goal_right),
        .frame_tick  (frame_tick),
        .new_game    (new_game),
        .score_left  (score_left),
        .score_right (score_right),
        .ball_enable (ball_enable),
        .serve       (serve),
        .serve_dir   (serve_dir),
        .win         (win),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output word: {score_left, score_right, ball_enable, serve, serve_dir, win, winner}
    typedef struct {
        string       name;
        logic        ng;
        logic        gl;
        logic        gr;
        logic        ft;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] pk(input logic [2:0] sl, input logic [2:0] sr,
                                       input logic be, input logic sv, input logic sd,
                                       input logic w, input logic wn);
        return {sl, sr, be, sv, sd, w, wn};
    endfunction

    task automatic add(input string nm, input logic ng, input logic gl, input logic gr,
                       input logic ft, input logic [10:0] exp);
        vec_t v;
        v.name = nm;
        v.ng   = ng;
        v.gl   = gl;
        v.gr   = gr;
        v.ft   = ft;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [10:0] exp);
        logic [10:0] got;
        got = {score_left, score_right, ball_enable, serve, serve_dir, win, winner};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got sl=%0d sr=%0d be=%b serve=%b dir=%b win=%b winner=%b, expected sl=%0d sr=%0d be=%b serve=%b dir=%b win=%b winner=%b",
                     nm, got[10:8], got[7:5], got[4], got[3], got[2], got[1], got[0],
                     exp[10:8], exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic ng, input logic gl, input logic gr, input logic ft);
        new_game   = ng;
        goal_left  = gl;
        goal_right = gr;
        frame_tick = ft;
        @(posedge clk);
        #1;
    endtask

    logic [10:0] after_t3;
    logic [10:0] over3;

    initial begin
        over3 = pk(3, 0, 0, 0, 1, 1, 0);
`ifdef SCORE_KEEPER_AUTO_RESTART_EN
        after_t3 = pk(0, 0, 0, 0, 0, 0, 0);
`else
        after_t3 = over3;
`endif
        add("idle0",          0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        add("tick1",          0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0));
        add("idle1",          0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        add("tick2_serve",    0, 0, 0, 1, pk(0, 0, 1, 1, 0, 0, 0));
        add("play_idle",      0, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0));
        add("gl_edge",        0, 1, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 9; i++)
            add("gl_held",    0, 1, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));
        add("gl_low",         0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));
        add("tick_a",         0, 0, 0, 1, pk(0, 1, 0, 0, 0, 0, 0));
        add("serve_a",        0, 0, 0, 1, pk(0, 1, 1, 1, 0, 0, 0));
        add("gr_edge",        0, 0, 1, 0, pk(1, 1, 0, 0, 1, 0, 0));
        add("gr_low",         0, 0, 0, 0, pk(1, 1, 0, 0, 1, 0, 0));
        add("sw_gl_ignored",  0, 1, 0, 0, pk(1, 1, 0, 0, 1, 0, 0));
        add("sw_gl_low",      0, 0, 0, 0, pk(1, 1, 0, 0, 1, 0, 0));
        add("tick_b",         0, 0, 0, 1, pk(1, 1, 0, 0, 1, 0, 0));
        add("serve_b",        0, 0, 0, 1, pk(1, 1, 1, 1, 1, 0, 0));
        add("both_edges",     0, 1, 1, 0, pk(1, 1, 0, 0, 1, 0, 0));
        add("both_low",       0, 0, 0, 0, pk(1, 1, 0, 0, 1, 0, 0));
        add("replay_tick",    0, 0, 0, 1, pk(1, 1, 0, 0, 1, 0, 0));
        add("replay_serve",   0, 0, 0, 1, pk(1, 1, 1, 1, 1, 0, 0));
        add("gr_edge2",       0, 0, 1, 0, pk(2, 1, 0, 0, 1, 0, 0));
        add("gr_low2",        0, 0, 0, 0, pk(2, 1, 0, 0, 1, 0, 0));
        add("tick_c",         0, 0, 0, 1, pk(2, 1, 0, 0, 1, 0, 0));
        add("serve_c",        0, 0, 0, 1, pk(2, 1, 1, 1, 1, 0, 0));
        add("ng_with_goal",   1, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        add("ng_after",       0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        add("tick_d",         0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0));
        add("serve_d",        0, 0, 0, 1, pk(0, 0, 1, 1, 0, 0, 0));
        add("l_pt1",          0, 0, 1, 0, pk(1, 0, 0, 0, 1, 0, 0));
        add("l_pt1_low",      0, 0, 0, 0, pk(1, 0, 0, 0, 1, 0, 0));
        add("tick_e",         0, 0, 0, 1, pk(1, 0, 0, 0, 1, 0, 0));
        add("serve_e",        0, 0, 0, 1, pk(1, 0, 1, 1, 1, 0, 0));
        add("l_pt2",          0, 0, 1, 0, pk(2, 0, 0, 0, 1, 0, 0));
        add("l_pt2_low",      0, 0, 0, 0, pk(2, 0, 0, 0, 1, 0, 0));
        add("tick_f",         0, 0, 0, 1, pk(2, 0, 0, 0, 1, 0, 0));
        add("serve_f",        0, 0, 0, 1, pk(2, 0, 1, 1, 1, 0, 0));
        add("l_win",          0, 0, 1, 0, over3);
        add("win_low",        0, 0, 0, 0, over3);
        add("go_gl_ignored",  0, 1, 0, 0, over3);
        add("go_gl_low",      0, 0, 0, 0, over3);
        add("go_gr_ignored",  0, 0, 1, 0, over3);
        add("go_gr_low",      0, 0, 0, 0, over3);
        add("go_tick1",       0, 0, 0, 1, over3);
        add("go_idle1",       0, 0, 0, 0, over3);
        add("go_tick2",       0, 0, 0, 1, over3);
        add("go_idle2",       0, 0, 0, 0, over3);
        add("go_tick3",       0, 0, 0, 1, after_t3);
        add("go_idle3",       0, 0, 0, 0, after_t3);
        add("go_idle4",       0, 0, 0, 0, after_t3);
        add("go_new_game",    1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pk(0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ng, vecs[i].gl, vecs[i].gr, vecs[i].ft);
            check(vecs[i].name, vecs[i].exp);
        end

        // Goal level already high at reset release must not score.
        step(0, 0, 0, 0);
        rst_n     = 1'b0;
        goal_left = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 0, 0);
        check("rel_goal_high", pk(0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        check("rel_serve", pk(0, 0, 1, 1, 0, 0, 0));
        step(0, 1, 0, 0);
        check("rel_no_phantom", pk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("rel_real_goal", pk(0, 1, 0, 0, 0, 0, 0));
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("pre_reset_serve", pk(0, 1, 1, 1, 0, 0, 0));

        // Asynchronous reset mid-game kills the in-flight serve pulse.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", pk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Right player wins: three goal_left points.
        for (int p = 1; p <= 3; p++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 1);
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
        end
        check("r_win", pk(0, 3, 0, 0, 0, 1, 1));
        step(1, 0, 0, 0);
        check("r_win_new_game", pk(0, 0, 0, 0, 0, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
